// File: rtl/step_sequencer_pkg.sv
// rtl/step_sequencer_pkg.sv - step numbering, sequencer states and one-hot step decode
package step_sequencer_pkg;

  localparam logic [1:0] STEP_FETCH  = 2'd0;
  localparam logic [1:0] STEP_DECODE = 2'd1;
  localparam logic [1:0] STEP_EXEC   = 2'd2;
  localparam logic [1:0] STEP_STORE  = 2'd3;

  localparam logic [0:0] SEQ_RUN  = 1'b0;
  localparam logic [0:0] SEQ_HALT = 1'b1;

  function automatic logic [3:0] step_decode(input logic [1:0] s);
    logic [3:0] oh;
    case (s)
      STEP_FETCH:  oh = 4'b0001;
      STEP_DECODE: oh = 4'b0010;
      STEP_EXEC:   oh = 4'b0100;
      default:     oh = 4'b1000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that either wraps or saturates at all-ones
module sat_counter #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !(SATURATE && (&count_q))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - four-step fetch/decode/exec/store sequencer with halt and statistics
// Breakpoint and single-step support is built when STEP_SEQ_DEBUG_EN is defined.
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int STEP_WIDTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock_input,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  mem_wait,
  input  logic                  halt_req,
  input  logic [15:0]           pc,
`ifdef STEP_SEQ_DEBUG_EN
  input  logic                  dbg_bp_en,
  input  logic [15:0]           dbg_bp_addr,
  input  logic                  dbg_single,
`endif
  output logic [STEP_WIDTH-1:0] step,
  output logic [3:0]            step_onehot,
  output logic                  instr_done,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  instr_count,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  localparam logic [STEP_WIDTH-1:0] S_FETCH = STEP_WIDTH'(STEP_FETCH);
  localparam logic [STEP_WIDTH-1:0] S_STORE = STEP_WIDTH'(STEP_STORE);

  logic [0:0]            state_q, state_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic                  instr_done_q, instr_done_d;

  logic in_run;
  logic advance;
  logic retire;
  logic stall_inc;
  logic bp_hit;
  logic stop_after;
  logic resume;

  assign in_run    = (state_q == SEQ_RUN);
  assign advance   = run & ~mem_wait;
  assign retire    = in_run & advance & (step_q == S_STORE) & ~bp_hit;
  assign stall_inc = in_run & run & mem_wait & ~bp_hit;

`ifdef STEP_SEQ_DEBUG_EN
  logic single_q, single_d;
  logic dbg_halt_q, dbg_halt_d;
  logic single_start;

  assign bp_hit       = in_run & run & (step_q == S_FETCH) & dbg_bp_en
                        & (pc == dbg_bp_addr) & ~single_q;
  assign single_start = ~in_run & run & dbg_single;
  assign stop_after   = single_q;
  // A debug halt is sticky: leave it by stepping or by disarming the breakpoint.
  assign resume       = single_start | (run & ~halt_req & ~dbg_halt_q);

  always_comb begin
    single_d   = single_q;
    dbg_halt_d = dbg_halt_q;
    if (single_start) begin
      single_d   = 1'b1;
      dbg_halt_d = 1'b0;
    end else if (retire) begin
      single_d = 1'b0;
      if (single_q) begin
        dbg_halt_d = 1'b1;
      end
    end else if (bp_hit) begin
      dbg_halt_d = 1'b1;
    end else if (!in_run && !dbg_bp_en) begin
      dbg_halt_d = 1'b0;
    end
  end

  always_ff @(posedge clock_input or posedge reset) begin
    if (reset) begin
      single_q   <= 1'b0;
      dbg_halt_q <= 1'b0;
    end else begin
      single_q   <= single_d;
      dbg_halt_q <= dbg_halt_d;
    end
  end
`else
  logic unused_pc;

  assign unused_pc  = ^pc;
  assign bp_hit     = 1'b0;
  assign stop_after = 1'b0;
  assign resume     = run & ~halt_req;
`endif

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    instr_done_d = 1'b0;
    if (in_run) begin
      if (bp_hit) begin
        state_d = SEQ_HALT;
        step_d  = S_FETCH;
      end else if (advance) begin
        if (step_q == S_STORE) begin
          step_d       = S_FETCH;
          instr_done_d = 1'b1;
          // The halt decision is taken only on the edge that retires the instruction.
          if (halt_req || stop_after) begin
            state_d = SEQ_HALT;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end
    end else if (resume) begin
      state_d = SEQ_RUN;
      step_d  = S_FETCH;
    end
  end

  always_ff @(posedge clock_input or posedge reset) begin
    if (reset) begin
      state_q      <= SEQ_RUN;
      step_q       <= S_FETCH;
      instr_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      instr_done_q <= instr_done_d;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH), .SATURATE(1'b0)) u_instr_cnt (
    .clk   (clock_input),
    .rst   (reset),
    .inc   (retire),
    .count (instr_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH), .SATURATE(1'b1)) u_stall_cnt (
    .clk   (clock_input),
    .rst   (reset),
    .inc   (stall_inc),
    .count (stall_count)
  );

  assign step        = step_q;
  assign halted      = (state_q == SEQ_HALT);
  assign step_onehot = halted ? 4'b0000 : step_decode(step_q[1:0]);
  assign instr_done  = instr_done_q;

endmodule
